// File: rtl/four_two_encoder_stream.sv
// Streaming one-hot to binary encoder with a 2-entry ordered output buffer.
// Non-one-hot codes are flagged and counted in a saturating counter.
module four_two_encoder_stream #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   head_idx_q, head_idx_d, tail_idx_q, tail_idx_d;
  logic               head_err_q, head_err_d, tail_err_q, tail_err_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [IDX_W-1:0]   enc_idx;
  logic [IDX_W:0]     ones;
  logic               enc_err;
  logic               accept, pop;

  // Scan MSB down to LSB so the lowest set bit wins on multi-hot codes.
  always_comb begin
    enc_idx = '0;
    ones    = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in_code[i]) begin
        enc_idx = IDX_W'(i);
        ones    = ones + (IDX_W + 1)'(1);
      end
    end
    enc_err = (ones != (IDX_W + 1)'(1));
  end

  assign in_ready  = !rst && (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_idx   = head_idx_q;
  assign out_err   = head_err_q;
  assign err_count = err_cnt_q;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    head_idx_d = head_idx_q;
    head_err_d = head_err_q;
    tail_idx_d = tail_idx_q;
    tail_err_d = tail_err_q;
    err_cnt_d  = err_cnt_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d    = ONE;
          head_idx_d = enc_idx;
          head_err_d = enc_err;
        end
      end
      ONE: begin
        if (accept && pop) begin
          head_idx_d = enc_idx;
          head_err_d = enc_err;
        end else if (accept) begin
          state_d    = FULL;
          tail_idx_d = enc_idx;
          tail_err_d = enc_err;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d    = ONE;
          head_idx_d = tail_idx_q;
          head_err_d = tail_err_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (accept && enc_err && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      head_idx_q <= '0;
      head_err_q <= 1'b0;
      tail_idx_q <= '0;
      tail_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      head_idx_q <= head_idx_d;
      head_err_q <= head_err_d;
      tail_idx_q <= tail_idx_d;
      tail_err_q <= tail_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_four_two_encoder_stream.sv
// Directed bench for four_two_encoder_stream: hand-computed expectations,
// immediate assertions at every comparison point.
module tb_four_two_encoder_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_idx;
  logic       out_err;
  logic [7:0] err_count;

  int compared   = 0;
  int mismatched = 0;

  four_two_encoder_stream #(.WIDTH(4), .IDX_W(2), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_err   (out_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, then settle just past the next rising edge.
  task automatic cyc(input logic v, input logic [3:0] c, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_code   = c;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] idx,
                         input logic err, input logic [7:0] cnt, input logic rdy);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      chk({tag, ".out_idx"}, 32'(out_idx), 32'(idx));
      chk({tag, ".out_err"}, 32'(out_err), 32'(err));
    end
    chk({tag, ".err_count"}, 32'(err_count), 32'(cnt));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    $display("step %s: in_ready=%0d out_valid=%0d out_idx=%0d out_err=%0d err_count=%0d",
             tag, in_ready, out_valid, out_idx, out_err, err_count);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_code   = 4'b0000;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_out("reset", 1'b0, 2'd0, 1'b0, 8'd0, 1'b1);
    chk("reset.out_idx", 32'(out_idx), 32'd0);
    chk("reset.out_err", 32'(out_err), 32'd0);

    // 1: reset asserted mid-cycle with one error entry buffered
    cyc(1'b1, 4'b0000, 1'b0);
    chk_out("t1.load", 1'b1, 2'd0, 1'b1, 8'd1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_out("t1.inrst", 1'b0, 2'd0, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_out("t1.release", 1'b0, 2'd0, 1'b0, 8'd0, 1'b1);

    // 2: back-to-back valid one-hot codes with consumer always ready
    cyc(1'b1, 4'b0001, 1'b1); chk_out("t2.c0", 1'b1, 2'd0, 1'b0, 8'd0, 1'b1);
    cyc(1'b1, 4'b0010, 1'b1); chk_out("t2.c1", 1'b1, 2'd1, 1'b0, 8'd0, 1'b1);
    cyc(1'b1, 4'b0100, 1'b1); chk_out("t2.c2", 1'b1, 2'd2, 1'b0, 8'd0, 1'b1);
    cyc(1'b1, 4'b1000, 1'b1); chk_out("t2.c3", 1'b1, 2'd3, 1'b0, 8'd0, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1); chk_out("t2.drain", 1'b0, 2'd0, 1'b0, 8'd0, 1'b1);

    // 3: zero-hot and multi-hot codes
    cyc(1'b1, 4'b0000, 1'b1); chk_out("t3.zero", 1'b1, 2'd0, 1'b1, 8'd1, 1'b1);
    cyc(1'b1, 4'b0110, 1'b1); chk_out("t3.0110", 1'b1, 2'd1, 1'b1, 8'd2, 1'b1);
    cyc(1'b1, 4'b1100, 1'b1); chk_out("t3.1100", 1'b1, 2'd2, 1'b1, 8'd3, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1); chk_out("t3.drain", 1'b0, 2'd0, 1'b0, 8'd3, 1'b1);

    // 4: backpressure fills the buffer, third code waits for the first pop
    cyc(1'b1, 4'b0010, 1'b0); chk_out("t4.acc1", 1'b1, 2'd1, 1'b0, 8'd3, 1'b1);
    cyc(1'b1, 4'b1000, 1'b0); chk_out("t4.full", 1'b1, 2'd1, 1'b0, 8'd3, 1'b0);
    cyc(1'b1, 4'b0100, 1'b0); chk_out("t4.hold", 1'b1, 2'd1, 1'b0, 8'd3, 1'b0);
    cyc(1'b1, 4'b0100, 1'b1); chk_out("t4.pop1", 1'b1, 2'd3, 1'b0, 8'd3, 1'b1);
    cyc(1'b1, 4'b0100, 1'b1); chk_out("t4.pop2", 1'b1, 2'd2, 1'b0, 8'd3, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1); chk_out("t4.drain", 1'b0, 2'd0, 1'b0, 8'd3, 1'b1);

    // 5: simultaneous accept and pop in ONE
    cyc(1'b1, 4'b0001, 1'b0); chk_out("t5.load", 1'b1, 2'd0, 1'b0, 8'd3, 1'b1);
    cyc(1'b1, 4'b1000, 1'b1); chk_out("t5.swap", 1'b1, 2'd3, 1'b0, 8'd3, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1); chk_out("t5.drain", 1'b0, 2'd0, 1'b0, 8'd3, 1'b1);

    // 6: counter saturation (starts at 3; 252 more errors reach 255)
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, 4'b0000, 1'b1);
      if (i == 250) chk("t6.cnt254", 32'(err_count), 32'd254);
      if (i == 251) chk("t6.cnt255", 32'(err_count), 32'd255);
    end
    chk_out("t6.sat", 1'b1, 2'd0, 1'b1, 8'd255, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1); chk_out("t6.drain", 1'b0, 2'd0, 1'b0, 8'd255, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_out("t6.rst", 1'b0, 2'd0, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_out("t6.release", 1'b0, 2'd0, 1'b0, 8'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
